ps2_scancode_rx: RTL
====================

# ps2_scancode_rx

Receive-only PS/2 keyboard front end that deframes the keyboard's serial clock/data lines into scan-code events for the keyboard driver FSM. It samples the open-drain lines, checks frame, parity and timeout, and folds 0xE0/0xF0 prefix bytes into flags. Each key event is presented as a stable `o_code` plus a one-cycle `o_valid` strobe, the `char`/`en` pair the driver consumes.

## Interface
- `TIMEOUT_CYCLES`, 50000: CLOCK_50 cycles with no PS2_CLK falling edge before an in-progress frame is aborted (1 ms at 50 MHz).
- `CLOCK_50`  in  1  system clock, 50 MHz.
- `i_rst_n`  in  1  reset; one clock, reset asynchronous and active-low.
- `PS2_CLK`  in  1  raw keyboard clock, asynchronous, idles high.
- `PS2_DAT`  in  1  raw keyboard data, asynchronous, idles high; the block never drives it.
- `o_code`  out  8  last accepted scan code; held until the next event.
- `o_valid`  out  1  one-cycle strobe: `o_code`/`o_break`/`o_ext` hold a new event.
- `o_break`  out  1  event was a release (preceded by 0xF0).
- `o_ext`  out  1  event was extended (preceded by 0xE0).
- `o_err`  out  1  one-cycle strobe on a parity, stop-bit or timeout error.

## Operation
- Sync: PS2_CLK and PS2_DAT each pass through a 2-FF synchronizer (reset to 1). A third PS2_CLK register detects falling edges (`prev=1, cur=0`). Data is sampled from the synchronized PS2_DAT on the falling-edge cycle.
- Frame: 11 bits: start(0), D0..D7 LSB first, odd parity, stop(1).
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge, if the data bit is 0, clear the bit counter and go to DATA. If it is 1, stay in IDLE as a glitch; no error.
  - DATA: shift the bit in; after the 8th bit go to PARITY.
  - PARITY: capture the bit, go to STOP.
  - STOP: on an edge, evaluate the frame and return to IDLE.
- Frame is good when `^{D7..D0,P} == 1` and stop == 1. Otherwise pulse `o_err`, discard the byte and clear both pending flags.
- Good byte handling:
  - 0xF0 sets `brk_pend`.
  - 0xE0 sets `ext_pend`.
  - Any other byte: `o_code <= byte`, `o_break <= brk_pend`, `o_ext <= ext_pend`, pulse `o_valid`, then clear both pending flags.
- Prefix bytes never produce `o_valid`.
- Timeout: in any state other than IDLE, a counter counts cycles since the last falling edge and resets on every edge. Reaching `TIMEOUT_CYCLES` returns to IDLE, pulses `o_err`, clears the pending flags and discards the partial byte. The counter is 16 bits and saturates.
- Reset mid-frame: state returns to IDLE, pending flags clear, all outputs return to reset values. A partial frame in flight after reset release is rejected by timeout or the start-bit check.

## Timing
- Reset values: `o_code=8'h00`, `o_valid=0`, `o_break=0`, `o_ext=0`, `o_err=0`; FSM in IDLE; counters 0.
- Edge detect lags the raw PS2_CLK fall by 3 cycles.
- `o_valid`/`o_err` assert on the cycle after the stop-bit edge is detected and last exactly 1 cycle.
- `o_code`, `o_break` and `o_ext` update in the same cycle `o_valid` asserts and then stay stable.
- `o_valid` and `o_err` are never high together.
- Minimum spacing between strobes is one full PS/2 frame (≥ about 600 µs), so the downstream block needs no backpressure and none is provided.

## Configuration
- `PS2_TYPEMATIC_FILTER_EN` defined:
  - A register holds `{ext,code}` of the last make event plus a valid bit.
  - A make event equal to it is suppressed: no `o_valid`, outputs unchanged.
  - A break event for that key clears the valid bit. Break events always emit.
  - Reset clears the valid bit.
- Undefined: every make event, including auto-repeat, emits `o_valid`.

## Test plan
- Frame 0x1D with parity=1, stop=1 -> one `o_valid` pulse, `o_code=8'h1D`, `o_break=0`, `o_ext=0`, `o_err=0`.
- Frames 0xF0 then 0x1D -> exactly one `o_valid` (after 0x1D), `o_code=8'h1D`, `o_break=1`, `o_ext=0`.
- Frames 0xE0 then 0x75 (parity=0) -> one `o_valid`, `o_code=8'h75`, `o_ext=1`, `o_break=0`.
- Frame 0x1B with parity=0 (bad) -> one `o_err` pulse, no `o_valid`, `o_code` unchanged. A following good 0x1B -> `o_valid`, `o_code=8'h1B`.
- Start bit plus 4 data bits, then PS2_CLK held high for 50001 cycles -> one `o_err` pulse and FSM in IDLE. A following good 0x1D frame is accepted.
- Frames 0x1D, 0x1D, 0x1D, F0 1D, 0x1D:
  - With `PS2_TYPEMATIC_FILTER_EN`: 3 `o_valid` pulses (make, break, make).
  - Without it: 5 `o_valid` pulses.

Source files
------------

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: receive-only PS/2 keyboard deframer.
// Synchronizes the raw PS2_CLK/PS2_DAT lines and detects PS2_CLK falling edges.
// Checks framing, odd parity and inactivity timeout.
// Folds 0xE0/0xF0 prefixes into o_ext/o_break.
// Each key event is emitted as o_code with a one-cycle o_valid strobe.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses auto-repeated make events.
module ps2_scancode_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       i_rst_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] o_code,
  output logic       o_valid,
  output logic       o_break,
  output logic       o_ext,
  output logic       o_err
);

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t      state_reg, state_next;
  logic        clk_s1_reg, clk_s2_reg, clk_prev_reg;
  logic        dat_s1_reg, dat_s2_reg;
  logic        fall;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  sh_reg, sh_next;
  logic        par_reg, par_next;
  logic [15:0] to_cnt_reg, to_cnt_next;
  logic        brk_pend_reg, brk_pend_next;
  logic        ext_pend_reg, ext_pend_next;
  logic [7:0]  code_reg, code_next;
  logic        valid_reg, valid_next;
  logic        break_reg, break_next;
  logic        ext_reg, ext_next;
  logic        err_reg, err_next;
  logic        frame_ok;
  logic        timed_out;
  logic        repeat_make;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0]  last_key_reg, last_key_next;
  logic        last_vld_reg, last_vld_next;
`endif

  // Two-stage synchronizers for both lines, plus a third clock stage for edge detection.
  always_ff @(posedge CLOCK_50 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_s1_reg   <= 1'b1;
      clk_s2_reg   <= 1'b1;
      clk_prev_reg <= 1'b1;
      dat_s1_reg   <= 1'b1;
      dat_s2_reg   <= 1'b1;
    end else begin
      clk_s1_reg   <= PS2_CLK;
      clk_s2_reg   <= clk_s1_reg;
      clk_prev_reg <= clk_s2_reg;
      dat_s1_reg   <= PS2_DAT;
      dat_s2_reg   <= dat_s1_reg;
    end
  end

  assign fall      = clk_prev_reg & ~clk_s2_reg;
  assign frame_ok  = (^{sh_reg, par_reg}) & dat_s2_reg;
  assign timed_out = (state_reg != IDLE) && !fall && (to_cnt_reg >= TO_LIMIT);

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign repeat_make = !brk_pend_reg && last_vld_reg && (last_key_reg == {ext_pend_reg, sh_reg});
`else
  assign repeat_make = 1'b0;
`endif

  // State, shift, counter, prefix and output registers.
  always_ff @(posedge CLOCK_50 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      sh_reg       <= '0;
      par_reg      <= 1'b0;
      to_cnt_reg   <= '0;
      brk_pend_reg <= 1'b0;
      ext_pend_reg <= 1'b0;
      code_reg     <= 8'h00;
      valid_reg    <= 1'b0;
      break_reg    <= 1'b0;
      ext_reg      <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      sh_reg       <= sh_next;
      par_reg      <= par_next;
      to_cnt_reg   <= to_cnt_next;
      brk_pend_reg <= brk_pend_next;
      ext_pend_reg <= ext_pend_next;
      code_reg     <= code_next;
      valid_reg    <= valid_next;
      break_reg    <= break_next;
      ext_reg      <= ext_next;
      err_reg      <= err_next;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  // Remembers the last emitted make key so auto-repeats of it can be dropped.
  always_ff @(posedge CLOCK_50 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_key_reg <= '0;
      last_vld_reg <= 1'b0;
    end else begin
      last_key_reg <= last_key_next;
      last_vld_reg <= last_vld_next;
    end
  end
`endif

  // Next-state logic: deframing, frame evaluation, prefix folding and timeout.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    sh_next       = sh_reg;
    par_next      = par_reg;
    brk_pend_next = brk_pend_reg;
    ext_pend_next = ext_pend_reg;
    code_next     = code_reg;
    valid_next    = 1'b0;
    break_next    = break_reg;
    ext_next      = ext_reg;
    err_next      = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
    last_key_next = last_key_reg;
    last_vld_next = last_vld_reg;
`endif

    // Inactivity counter only runs mid-frame and restarts on every clock edge.
    if (state_reg == IDLE || fall) begin
      to_cnt_next = '0;
    end else if (to_cnt_reg != 16'hFFFF) begin
      to_cnt_next = to_cnt_reg + 16'd1;
    end else begin
      to_cnt_next = to_cnt_reg;
    end

    case (state_reg)
      IDLE: begin
        // A high bit here is a glitch or mid-frame join; silently ignore it.
        if (fall && !dat_s2_reg) begin
          bit_cnt_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (fall) begin
          sh_next      = {dat_s2_reg, sh_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_next   = dat_s2_reg;
          state_next = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_next = IDLE;
          if (!frame_ok) begin
            err_next      = 1'b1;
            brk_pend_next = 1'b0;
            ext_pend_next = 1'b0;
          end else if (sh_reg == 8'hF0) begin
            brk_pend_next = 1'b1;
          end else if (sh_reg == 8'hE0) begin
            ext_pend_next = 1'b1;
          end else begin
            brk_pend_next = 1'b0;
            ext_pend_next = 1'b0;
            if (!repeat_make) begin
              code_next  = sh_reg;
              break_next = brk_pend_reg;
              ext_next   = ext_pend_reg;
              valid_next = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
              if (brk_pend_reg) begin
                if (last_key_reg == {ext_pend_reg, sh_reg}) last_vld_next = 1'b0;
              end else begin
                last_key_next = {ext_pend_reg, sh_reg};
                last_vld_next = 1'b1;
              end
`endif
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A stalled keyboard aborts the frame; the partial byte is dropped.
    if (timed_out) begin
      state_next    = IDLE;
      err_next      = 1'b1;
      brk_pend_next = 1'b0;
      ext_pend_next = 1'b0;
    end
  end

  assign o_code  = code_reg;
  assign o_valid = valid_reg;
  assign o_break = break_reg;
  assign o_ext   = ext_reg;
  assign o_err   = err_reg;

endmodule
